// File: rtl/last_cnt_pkg.sv
// last_cnt_pkg: shared op encoding and width helpers for the last_cnt_mq tracker
package last_cnt_pkg;

    typedef enum logic [2:0] {LC_NOP, LC_ENQ, LC_DEQ, LC_REPL, LC_CLR} lc_op_t;

    // queue-select width, never narrower than one bit
    function automatic int unsigned lc_qw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned lc_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // a count must reach DEPTH itself, hence DEPTH+1 states
    function automatic int unsigned lc_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/last_cnt_lane.sv
// last_cnt_lane: one queue's occupancy counter with derived last/full/empty; optional high-water mark under LAST_CNT_HWM_EN
module last_cnt_lane
    import last_cnt_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = lc_aw(DEPTH),
    parameter int unsigned CW    = lc_cw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  lc_op_t        op,
    output logic [CW-1:0] count,
    output logic [AW-1:0] last,
    output logic          full,
    output logic          empty,
    output logic          rej
`ifdef LAST_CNT_HWM_EN
    ,
    output logic [CW-1:0] hwm
`endif
);

    logic [CW-1:0] count_q, count_d;
    logic          upd;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign rej   = ((op == LC_ENQ) && full) || ((op == LC_DEQ || op == LC_REPL) && empty);
    assign upd   = en && !rej;
    assign count = count_q;
    assign last  = empty ? '0 : AW'(count_q - CW'(1));

    // next count for an accepted op; replace and no-op leave it alone
    always_comb
        count_d = !upd ? count_q :
                  (op == LC_CLR) ? '0 :
                  (op == LC_ENQ) ? count_q + CW'(1) :
                  (op == LC_DEQ) ? count_q - CW'(1) : count_q;

    // occupancy register
    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;

`ifdef LAST_CNT_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    assign hwm = hwm_q;

    // mark tracks the peak count; clear does not lower it
    always_comb hwm_d = (upd && count_d > hwm_q) ? count_d : hwm_q;

    // high-water mark register, only reset lowers it
    always_ff @(posedge clk or negedge rst)
        if (!rst) hwm_q <= '0;
        else      hwm_q <= hwm_d;
`endif

endmodule

// File: rtl/last_cnt_mq.sv
// last_cnt_mq: multi-queue last-pointer tracker; LAST_CNT_HWM_EN adds per-queue high-water marks on port hwm
module last_cnt_mq
    import last_cnt_pkg::*;
#(
    parameter int unsigned NQ    = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = lc_aw(DEPTH),
    parameter int unsigned CW    = lc_cw(DEPTH),
    localparam int unsigned QW   = lc_qw(NQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [QW-1:0]    qsel,
    input  logic             enq,
    input  logic             deq,
    input  logic             clr,
    input  logic             done,
    input  logic             err_clr,
    output logic [NQ*AW-1:0] new_last,
    output logic [NQ*CW-1:0] count,
    output logic [NQ-1:0]    full,
    output logic [NQ-1:0]    empty,
    output logic             upd_valid,
    output logic             err
`ifdef LAST_CNT_HWM_EN
    ,
    output logic [NQ*CW-1:0] hwm
`endif
);

    lc_op_t        op;
    logic [NQ-1:0] sel, rej;
    logic          bad_q, any_rej, upd_valid_q, upd_valid_d, err_q, err_d;

    assign bad_q   = 32'(qsel) >= NQ;
    assign any_rej = |(sel & rej);

    // priority decode of the request lines and per-lane enable
    always_comb begin
        op = clr ? LC_CLR : (enq && deq) ? LC_REPL : enq ? LC_ENQ : deq ? LC_DEQ : LC_NOP;
        for (int i = 0; i < NQ; i++) sel[i] = done && (32'(qsel) == i);
    end

    // accept pulse and sticky error; a fresh error beats err_clr
    always_comb begin
        upd_valid_d = done && !bad_q && !any_rej;
        err_d       = (done && (bad_q || any_rej)) ? 1'b1 : err_clr ? 1'b0 : err_q;
    end

    // status registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            upd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            upd_valid_q <= upd_valid_d;
            err_q       <= err_d;
        end

    assign upd_valid = upd_valid_q;
    assign err       = err_q;

    for (genvar i = 0; i < NQ; i++) begin : g_lane
        last_cnt_lane #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (sel[i]),
            .op    (op),
            .count (count[i*CW +: CW]),
            .last  (new_last[i*AW +: AW]),
            .full  (full[i]),
            .empty (empty[i]),
            .rej   (rej[i])
`ifdef LAST_CNT_HWM_EN
            ,
            .hwm   (hwm[i*CW +: CW])
`endif
        );
    end

endmodule

// File: doc/last_cnt_mq.md
# last_cnt_mq

Parametrised multi-queue last-pointer tracker for the QuickQ datapath. It keeps one occupancy counter per logical queue and derives each queue's last-entry address, full and empty flags from that counter. A counter updates on a `done`-qualified enqueue, dequeue, replace or clear. Overflow and underflow are rejected and flagged, not wrapped. It replaces the single-queue, unguarded last-address counter and is driven by the queue controller at the end of each operation.

## Interface
- `NQ`, 4: number of independent queues (1..16).
- `DEPTH`, 16: entries per queue (2..1024; need not be a power of two).
- `AW`, `$clog2(DEPTH)`: width of a last-address output.
- `CW`, `$clog2(DEPTH+1)`: width of an occupancy count.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `qsel`  in  `$clog2(NQ)` (min 1)  queue addressed by the current operation.
- `enq`  in  1  enqueue request.
- `deq`  in  1  dequeue request.
- `clr`  in  1  empty the selected queue.
- `done`  in  1  one-cycle strobe that qualifies `enq`/`deq`/`clr`/`qsel`.
- `new_last`  out  `NQ*AW`  per-queue last-entry address, packed with queue 0 in the LSBs.
- `count`  out  `NQ*CW`  per-queue occupancy, packed the same way.
- `full`  out  `NQ`  `count == DEPTH`.
- `empty`  out  `NQ`  `count == 0`.
- `upd_valid`  out  1  pulses when a `done` operation was accepted.
- `err`  out  1  sticky overflow/underflow/bad-`qsel` flag.
- `err_clr`  in  1  synchronous clear of `err`.

## Operation
- When `done` is low, all inputs except `err_clr` are ignored and no state changes.
- On `done` high, the op for queue `qsel` is resolved in this priority:
  - `clr`: count ← 0.
  - `enq` & `deq`: replace; count unchanged. Legal when count > 0. When count == 0 it is an underflow.
  - `enq` only: count + 1 if not full. If full, this is an overflow.
  - `deq` only: count − 1 if not empty. If empty, this is an underflow.
  - None of the above: no-op. `upd_valid` still pulses.
- Overflow, underflow, or `qsel` ≥ NQ: no counter changes, `upd_valid` stays low, `err` ← 1.
- `new_last[q]` = count[q] − 1 when not empty, and 0 when empty.
- `full` and `empty` are combinational decodes of the registered counts.
- Only the selected queue changes. All other queues hold.
- Counts never wrap. All arithmetic is performed at CW bits.
- `err_clr` clears `err`. If a new error occurs in the same cycle, `err` is set instead (set wins).

## Timing
- Reset (asynchronous assert, synchronous release) gives: all counts 0, `new_last` 0, `empty` all 1, `full` all 0, `upd_valid` 0, `err` 0.
- `count` and `new_last` are registered. An op sampled at edge N is visible after edge N; latency is 1 cycle.
- `upd_valid` is registered and is high for exactly the cycle after the accepting edge.
- Back-to-back `done` strobes on consecutive cycles are supported, including to the same queue. Each op uses the count already updated by the previous op.
- Asserting `rst` mid-operation discards the in-flight op. There is no `upd_valid` for it.

## Configuration
- `LAST_CNT_HWM_EN` defined:
  - Adds a per-queue high-water mark register and output `hwm` (`NQ*CW`, reset 0).
  - The mark updates to the new count on any accepted op that exceeds it.
  - `clr` does not reset it. Only `rst` does.
- Undefined: no `hwm` port and no high-water-mark logic. All other behaviour is identical.

## Structure
- Package `last_cnt_pkg` holds:
  - the op enum `lc_op_t` {LC_NOP, LC_ENQ, LC_DEQ, LC_REPL, LC_CLR};
  - the width helper functions.
- Sub-module `last_cnt_lane`: one per queue, generated NQ times. Each lane:
  - holds the count register and the optional high-water mark;
  - takes a decoded op plus a lane enable;
  - returns count, last, full, empty and a reject signal.
- Top level holds:
  - op decode and `qsel` range check;
  - the `upd_valid` and `err` registers.

## Test plan
All scenarios use NQ=4, DEPTH=8.
- Reset, then read outputs -> all counts 0, `new_last` 0, `empty`=4'hF, `full`=0, `err`=0.
- 8 enqueues to q2 -> count[2]=8, `new_last[2]`=7, `full[2]`=1. A 9th enqueue -> `err`=1, count unchanged, no `upd_valid`.
- Dequeue q1 while empty -> `err`=1, count[1]=0. Then `err_clr` -> `err`=0.
- Set q0 to count 3, then `enq`&`deq` together -> count[0] stays 3 and `upd_valid` pulses. The same op on empty q3 -> `err`=1.
- Back-to-back `done`: enq q0, enq q1, deq q0, clr q1 on consecutive cycles -> final count[0]=0, count[1]=0. `upd_valid` is high for 4 consecutive cycles.
- With `LAST_CNT_HWM_EN`: enqueue 5 to q0, dequeue 3, `clr` -> `hwm[0]`=5, count[0]=0. Then assert `rst` -> `hwm[0]`=0.
